// File: rtl/alu_multiciclo_pkg.sv
// alu_multiciclo_pkg: opcode/state types shared by the multi-cycle ALU and its testbench.
package alu_multiciclo_pkg;
    typedef enum logic [4:0] {
        ADD = 5'b00000, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASSY, EQ, NE, GE, GEU,
        MUL = 5'b10000, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } alu_op_t;
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction
endpackage

// File: rtl/alu_multiciclo_if.sv
// alu_multiciclo_if: start/done operand and result bundle of the multi-cycle ALU.
interface alu_multiciclo_if #(parameter int WIDTH = 32);
    logic             start, flush;
    logic [4:0]       control;
    logic [WIDTH-1:0] x, y;
    logic             busy, done;
    logic [WIDTH-1:0] resultado;
    logic             zero, err;
    modport master (output start, flush, control, x, y, input busy, done, resultado, zero, err);
    modport slave (input start, flush, control, x, y, output busy, done, resultado, zero, err);
endinterface

// File: rtl/alu_multiciclo_mdu_iter.sv
// alu_multiciclo_mdu_iter: iterative shift-add multiplier / restoring divider on magnitudes.
// One WIDTH+1 adder serves both; res is the sign-fixed value after the step in progress.
module alu_multiciclo_mdu_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             kill,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cnt_last,
    output logic [WIDTH-1:0] res
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0] cnt;
    logic run, sa, sb, bz, a_sg, b_sg, div, ge;
    logic [2:0] opr;
    logic [WIDTH-1:0] hi, lo, m, nhi, nlo, ma, mb, q, r;
    logic [WIDTH:0] op1, op2;
    logic [WIDTH+1:0] sum;
    logic [2*WIDTH-1:0] p;
    assign a_sg = op[2] ? !op[0] : op[1:0] != 2'b11;
    assign b_sg = op[2] ? !op[0] : !op[1];
    assign ma = (a_sg && a[WIDTH-1]) ? -a : a;
    assign mb = (b_sg && b[WIDTH-1]) ? -b : b;
    assign div = opr[2];
    // mul: hi += lo[0] ? m : 0 then shift right; div: trial-subtract m from {hi, next dividend bit}
    assign op1 = div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    assign op2 = div ? ~{1'b0, m} : (lo[0] ? {1'b0, m} : '0);
    assign sum = {1'b0, op1} + {1'b0, op2} + {{(WIDTH+1){1'b0}}, div};
    assign ge = sum[WIDTH+1];
    assign nhi = div ? (ge ? sum[WIDTH-1:0] : op1[WIDTH-1:0]) : sum[WIDTH:1];
    assign nlo = div ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    assign p = (sa ^ sb) ? -{nhi, nlo} : {nhi, nlo};
    assign q = ((sa ^ sb) && !bz) ? -nlo : nlo;
    assign r = sa ? -nhi : nhi;
    assign res = div ? (opr[1] ? r : q) : (opr[1:0] == 2'b00 ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH]);
    assign cnt_last = run && cnt == CW'(WIDTH-1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
            opr <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            bz <= 1'b0;
            hi <= '0;
            lo <= '0;
            m <= '0;
        end else if (kill) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= '0;
            run <= 1'b1;
            opr <= op;
            sa <= a_sg && a[WIDTH-1];
            sb <= b_sg && b[WIDTH-1];
            bz <= b == '0;
            hi <= '0;
            lo <= op[2] ? ma : mb;
            m <= op[2] ? mb : ma;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            run <= !cnt_last;
            hi <= nhi;
            lo <= nlo;
        end
    end
endmodule

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: execute-stage ALU; single-cycle base ops, WIDTH-cycle RV32M mul/div.
module alu_multiciclo
    import alu_multiciclo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    alu_multiciclo_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    state_t state, nxt;
    alu_op_t op;
    logic mop, ilg, acc, upd, cnt_last, zero_q, err_q;
    logic [WIDTH-1:0] base, mdu_res, res_in, res_q;
    assign op = alu_op_t'(bus.control);
    assign mop = is_mop(bus.control) && (bus.control[2] ? DIV_EN : MUL_EN);
    // any 1xxxx code that is not an enabled M-op is illegal, as is the unused base slot
    assign ilg = bus.control[4] ? !mop : bus.control == 5'b01111;
    assign acc = bus.start && !bus.flush && state != CALC;
    assign upd = (acc && !mop) || (state == CALC && cnt_last && !bus.flush);
    assign res_in = state == CALC ? mdu_res : ilg ? '0 : base;
    always_comb begin
        base = '0;
        case (op)
            ADD:     base = bus.x + bus.y;
            SUB:     base = bus.x - bus.y;
            AND:     base = bus.x & bus.y;
            OR:      base = bus.x | bus.y;
            XOR:     base = bus.x ^ bus.y;
            SLL:     base = bus.x << bus.y[SW-1:0];
            SRL:     base = bus.x >> bus.y[SW-1:0];
            SRA:     base = $signed(bus.x) >>> bus.y[SW-1:0];
            SLT:     base = WIDTH'($signed(bus.x) < $signed(bus.y));
            SLTU:    base = WIDTH'(bus.x < bus.y);
            PASSY:   base = bus.y;
            EQ:      base = WIDTH'(bus.x == bus.y);
            NE:      base = WIDTH'(bus.x != bus.y);
            GE:      base = WIDTH'($signed(bus.x) >= $signed(bus.y));
            GEU:     base = WIDTH'(bus.x >= bus.y);
            default: base = '0;
        endcase
    end
    always_comb begin
        nxt = bus.flush ? IDLE : state == CALC ? (cnt_last ? FIN : CALC) : !bus.start ? IDLE : mop ? CALC : FIN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            zero_q <= 1'b0;
            err_q <= 1'b0;
        end else if (upd) begin
            res_q <= res_in;
            zero_q <= res_in == '0;
            err_q <= state != CALC && ilg;
        end
    end
    assign bus.busy = state == CALC;
    assign bus.done = state == FIN;
    assign bus.resultado = res_q;
    assign bus.zero = zero_q;
    assign bus.err = err_q;
    alu_multiciclo_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk(clk),
        .rst_n(rst_n),
        .load(acc && mop),
        .kill(bus.flush),
        .op(bus.control[2:0]),
        .a(bus.x),
        .b(bus.y),
        .cnt_last(cnt_last),
        .res(mdu_res)
    );
endmodule

// File: tb/tb_alu_multiciclo.sv
// tb_alu_multiciclo: scoreboard bench; arithmetic reference model, directed and random ops.
module tb_alu_multiciclo;
    import alu_multiciclo_pkg::*;
    localparam int W = 32;
    localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
    typedef struct packed {logic [W-1:0] res; logic err;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass = 0;
    int total = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] last_res = '0;
    alu_multiciclo_if #(.WIDTH(W)) bus ();
    alu_multiciclo_if #(.WIDTH(W)) bus0 ();
    alu_multiciclo #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_multiciclo #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0] pu;
        logic ovf;
        ovf = x == MIN && y == '1;
        e.err = 1'b0;
        e.res = '0;
        case (op)
            5'd0:  e.res = x + y;
            5'd1:  e.res = x - y;
            5'd2:  e.res = x & y;
            5'd3:  e.res = x | y;
            5'd4:  e.res = x ^ y;
            5'd5:  e.res = x << y[4:0];
            5'd6:  e.res = x >> y[4:0];
            5'd7:  e.res = $signed(x) >>> y[4:0];
            5'd8:  e.res = W'($signed(x) < $signed(y));
            5'd9:  e.res = W'(x < y);
            5'd10: e.res = y;
            5'd11: e.res = W'(x == y);
            5'd12: e.res = W'(x != y);
            5'd13: e.res = W'($signed(x) >= $signed(y));
            5'd14: e.res = W'(x >= y);
            5'd16: e.res = x * y;
            5'd17: begin
                ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                e.res = ps[2*W-1:W];
            end
            5'd18: begin
                ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{1'b0}}, y});
                e.res = ps[2*W-1:W];
            end
            5'd19: begin
                pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                e.res = pu[2*W-1:W];
            end
            5'd20: if (y == '0) e.res = '1; else if (ovf) e.res = MIN; else e.res = $signed(x) / $signed(y);
            5'd21: if (y == '0) e.res = '1; else e.res = x / y;
            5'd22: if (y == '0) e.res = x; else if (ovf) e.res = '0; else e.res = $signed(x) % $signed(y);
            5'd23: if (y == '0) e.res = x; else e.res = x % y;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return MIN;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("resultado", bus.resultado, mon_e.res);
                chk("zero", bus.zero, mon_e.res == '0);
                chk("err", bus.err, mon_e.err);
            end
        end
    end

    // called at a negedge; returns at the negedge where DONE is seen, so the next call starts in FIN
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int ign = 0);
        exp_t e;
        int got, nb;
        bit mop;
        e = model(op, x, y);
        mop = op[4:3] == 2'b10;
        got = 0;
        nb = 0;
        bus.control = op;
        bus.x = x;
        bus.y = y;
        bus.start = 1'b1;
        sb.push_back(e);
        for (int i = 1; i <= W + 4 && got == 0; i++) begin
            @(negedge clk);
            bus.start = i == ign;
            bus.control = i == ign ? 5'd0 : 5'($urandom);
            bus.x = $urandom;
            bus.y = $urandom;
            nb += int'(bus.busy);
            if (bus.done) got = i;
        end
        chk($sformatf("latency_op%0d", op), got, mop ? W + 1 : 1);
        chk($sformatf("busy_cycles_op%0d", op), nb, mop ? W : 0);
        last_res = e.res;
    endtask

    task automatic flush_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int nd;
        nd = 0;
        bus.control = op;
        bus.x = x;
        bus.y = y;
        bus.start = 1'b1;
        for (int i = 1; i <= W + 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = i == 5;
            nd += int'(bus.done);
            if (i == 6) begin
                chk("flush_busy", bus.busy, 0);
                chk("flush_res_kept", bus.resultado, last_res);
                chk("flush_zero_kept", bus.zero, last_res == '0);
            end
        end
        chk("flush_no_done", nd, 0);
    endtask

    initial begin
        int nd;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.control = '0;
        bus.x = '0;
        bus.y = '0;
        bus0.start = 1'b0;
        bus0.flush = 1'b0;
        bus0.control = '0;
        bus0.x = '0;
        bus0.y = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_res", bus.resultado, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(ADD, 7, 5);
        run_op(SUB, 5, 5);
        run_op(SLT, '1, 1);
        run_op(SLTU, '1, 1);
        run_op(SRA, MIN, 4);
        run_op(AND, 6, 3);
        run_op(MULHU, '1, 2, 10);
        run_op(MUL, '1, 2);
        run_op(DIV, -7, 2);
        run_op(REM, -7, 2);
        run_op(DIVU, 9, 0);
        run_op(REMU, 9, 0);
        run_op(DIV, MIN, '1);
        run_op(REM, MIN, '1);
        run_op(5'b11000, 1, 1);
        run_op(ADD, 100, 23);
        flush_op(MUL, 1234, 5678);
        bus.control = ADD;
        bus.x = 1;
        bus.y = 1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("flush_cancel_done", bus.done, 0);
        chk("flush_cancel_busy", bus.busy, 0);
        chk("flush_cancel_res", bus.resultado, last_res);
        run_op(ADD, 5, 6);
        bus.control = MULHU;
        bus.x = '1;
        bus.y = '1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_res", bus.resultado, 0);
        chk("arst_zero", bus.zero, 0);
        chk("arst_err", bus.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            nd += int'(bus.done);
        end
        chk("arst_no_done", nd, 0);
        for (int k = 0; k < 60; k++) run_op(5'($urandom_range(0, 31)), pick(), pick());
        bus0.control = MUL;
        bus0.x = 3;
        bus0.y = 4;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        chk("nomul_done", bus0.done, 1);
        chk("nomul_err", bus0.err, 1);
        chk("nomul_busy", bus0.busy, 0);
        chk("nomul_res", bus0.resultado, 0);
        chk("nomul_zero", bus0.zero, 1);
        bus0.control = DIV;
        bus0.x = 8;
        bus0.y = 2;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        chk("nomul_div_busy", bus0.busy, 1);
        nd = 0;
        for (int i = 2; i <= W + 4 && nd == 0; i++) begin
            @(negedge clk);
            if (bus0.done) nd = i;
        end
        chk("nomul_div_latency", nd, W + 1);
        chk("nomul_div_res", bus0.resultado, 4);
        chk("nomul_div_err", bus0.err, 0);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
